// File: rtl/qif_neuron_array_if.sv
// Control, configuration and observation bundle for the QIF neuron array.
// The master side drives stimulus and configuration; the slave side is the array.
interface qif_neuron_array_if #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4,
   parameter int CNT_W = 8,
   parameter int SEL_W = 2
);
   logic                    ena;
   logic [N_CH*WIDTH-1:0]   i_in;
   logic [WIDTH-1:0]        v_thresh;
   logic [WIDTH-1:0]        v_reset;
   logic [WIDTH-1:0]        v_rest;
   logic [SEL_W-1:0]        sel;
   logic                    cnt_clr;
   logic [N_CH-1:0]         spike;
   logic [WIDTH-1:0]        v_out;
   logic [CNT_W-1:0]        cnt_out;
   logic [N_CH-1:0]         refrac;

   modport master (
      output ena, i_in, v_thresh, v_reset, v_rest, sel, cnt_clr,
      input  spike, v_out, cnt_out, refrac
   );

   modport slave (
      input  ena, i_in, v_thresh, v_reset, v_rest, sel, cnt_clr,
      output spike, v_out, cnt_out, refrac
   );
endinterface

// File: rtl/qif_neuron_array.sv
// N_CH quadratic integrate-and-fire neurons stepped in parallel; spike registered on the crossing edge.
// No backpressure: ena low freezes all state and suppresses spikes, cnt_clr acts regardless of ena.
module qif_neuron_array #(
   parameter int WIDTH  = 8,
   parameter int N_CH   = 4,
   parameter int SHIFT  = 4,
   parameter int REFRAC = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   qif_neuron_array_if.slave bus
);
   localparam int SW    = 2*WIDTH + 3;
   localparam int QW    = 2*WIDTH + 2;
   localparam int RC_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(REFRAC);
   localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);

   logic [WIDTH-1:0]        r_v     [N_CH];
   logic [RC_W-1:0]         r_rc    [N_CH];
   logic [CNT_W-1:0]        r_cnt   [N_CH];
   logic [N_CH-1:0]         r_spike;

   logic [WIDTH-1:0]        w_in    [N_CH];
   logic signed [WIDTH:0]   w_d     [N_CH];
   logic signed [QW-1:0]    w_dx    [N_CH];
   logic [QW-1:0]           w_q     [N_CH];
   logic signed [SW-1:0]    w_s     [N_CH];
   logic [WIDTH-1:0]        w_sc    [N_CH];
   logic [N_CH-1:0]         w_fire;

   // The sum is wide enough that v + q + i never wraps before the clamp.
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         w_in[k] = bus.i_in[k*WIDTH +: WIDTH];
         w_d[k]  = $signed({1'b0, r_v[k]}) - $signed({1'b0, bus.v_rest});
         w_dx[k] = {{(QW-WIDTH-1){w_d[k][WIDTH]}}, w_d[k]};
         w_q[k]  = $unsigned(w_dx[k] * w_dx[k]) >> SHIFT;
         w_s[k]  = $signed({{(SW-WIDTH){1'b0}}, r_v[k]})
                 + $signed({1'b0, w_q[k]})
                 + $signed({{(SW-WIDTH){w_in[k][WIDTH-1]}}, w_in[k]});
         if (w_s[k][SW-1])
            w_sc[k] = '0;
         else if (|w_s[k][SW-2:WIDTH])
            w_sc[k] = '1;
         else
            w_sc[k] = w_s[k][WIDTH-1:0];
         w_fire[k] = (w_sc[k] >= bus.v_thresh);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spike <= '0;
         for (int k = 0; k < N_CH; k++) begin
            r_v[k]   <= '0;
            r_rc[k]  <= '0;
            r_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (bus.ena) begin
               if (r_rc[k] != '0) begin
                  r_v[k]     <= bus.v_reset;
                  r_rc[k]    <= r_rc[k] - RC_ONE;
                  r_spike[k] <= 1'b0;
               end else if (w_fire[k]) begin
                  r_v[k]     <= bus.v_reset;
                  r_rc[k]    <= RC_LOAD;
                  r_spike[k] <= 1'b1;
                  if (r_cnt[k] != CNT_MAX)
                     r_cnt[k] <= r_cnt[k] + CNT_ONE;
               end else begin
                  r_v[k]     <= w_sc[k];
                  r_spike[k] <= 1'b0;
               end
            end else begin
               r_spike[k] <= 1'b0;
            end
            // Placed last so a clear beats a same-edge increment.
            if (bus.cnt_clr)
               r_cnt[k] <= '0;
         end
      end
   end

   always_comb begin
      bus.v_out   = '0;
      bus.cnt_out = '0;
      if ({1'b0, bus.sel} < N_CH_L) begin
         bus.v_out   = r_v[bus.sel];
         bus.cnt_out = r_cnt[bus.sel];
      end
      for (int k = 0; k < N_CH; k++)
         bus.refrac[k] = (r_rc[k] != '0);
   end

   assign bus.spike = r_spike;
endmodule

// File: tb/tb_qif_neuron_array.sv
// Randomised and directed bench for qif_neuron_array against an integer-arithmetic neuron model.
module tb_qif_neuron_array;
   localparam int WIDTH  = 8;
   localparam int N_CH   = 4;
   localparam int SHIFT  = 4;
   localparam int REFRAC = 3;
   localparam int CNT_W  = 8;
   localparam int SEL_W  = 2;
   localparam int VMAX   = (1 << WIDTH) - 1;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   qif_neuron_array_if #(.WIDTH(WIDTH), .N_CH(N_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

   qif_neuron_array #(
      .WIDTH(WIDTH), .N_CH(N_CH), .SHIFT(SHIFT), .REFRAC(REFRAC), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int mv  [N_CH];
   int mrc [N_CH];
   int mcnt[N_CH];
   bit msp [N_CH];

   function automatic int in_of(int k);
      logic signed [WIDTH-1:0] t;
      t = bus.i_in[k*WIDTH +: WIDTH];
      return int'(t);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N_CH; k++) begin
         mv[k] = 0; mrc[k] = 0; mcnt[k] = 0; msp[k] = 0;
      end
   endtask

   // One neuron step from the behavioural rules, using the inputs held for the coming edge.
   task automatic model_step();
      int d, s;
      for (int k = 0; k < N_CH; k++) begin
         if (bus.ena) begin
            if (mrc[k] > 0) begin
               mv[k] = int'(bus.v_reset); mrc[k]--; msp[k] = 0;
            end else begin
               d = mv[k] - int'(bus.v_rest);
               s = mv[k] + ((d * d) >> SHIFT) + in_of(k);
               if (s < 0) s = 0;
               if (s > VMAX) s = VMAX;
               if (s >= int'(bus.v_thresh)) begin
                  mv[k] = int'(bus.v_reset); mrc[k] = REFRAC; msp[k] = 1;
                  if (mcnt[k] < CMAX) mcnt[k]++;
               end else begin
                  mv[k] = s; msp[k] = 0;
               end
            end
         end else begin
            msp[k] = 0;
         end
         if (bus.cnt_clr) mcnt[k] = 0;
      end
   endtask

   function automatic logic [N_CH-1:0] exp_spike();
      logic [N_CH-1:0] r;
      for (int k = 0; k < N_CH; k++) r[k] = msp[k];
      return r;
   endfunction

   function automatic logic [N_CH-1:0] exp_refrac();
      logic [N_CH-1:0] r;
      for (int k = 0; k < N_CH; k++) r[k] = (mrc[k] != 0);
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] exp_vout();
      return (int'(bus.sel) < N_CH) ? WIDTH'(mv[bus.sel]) : '0;
   endfunction

   function automatic logic [CNT_W-1:0] exp_cnt();
      return (int'(bus.sel) < N_CH) ? CNT_W'(mcnt[bus.sel]) : '0;
   endfunction

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(int k, int val);
      bus.i_in[k*WIDTH +: WIDTH] = WIDTH'(val);
   endtask

   task automatic test_reset();
      bus.ena = 1'b1; bus.i_in = '0; bus.v_thresh = 8'd200; bus.v_reset = 8'd20;
      bus.v_rest = '0; bus.sel = '0; bus.cnt_clr = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (bus.spike !== '0) begin n_fail++; $display("FAIL reset_spike got=%b exp=0", bus.spike); end
      n_tests++; if (bus.refrac !== '0) begin n_fail++; $display("FAIL reset_refrac got=%b exp=0", bus.refrac); end
      n_tests++; if (bus.v_out !== '0) begin n_fail++; $display("FAIL reset_vout got=%0d exp=0", bus.v_out); end
      n_tests++; if (bus.cnt_out !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", bus.cnt_out); end
      rst_n = 1'b1;
   endtask

   task automatic test_quiet();
      for (int c = 0; c < 8; c++) begin
         bus.sel = SEL_W'(c % N_CH);
         step();
         n_tests++; if (bus.v_out !== 8'd0) begin n_fail++; $display("FAIL quiet_vout c=%0d got=%0d exp=0", c, bus.v_out); end
         n_tests++; if (bus.spike !== exp_spike()) begin n_fail++; $display("FAIL quiet_spike c=%0d got=%b exp=%b", c, bus.spike, exp_spike()); end
      end
   endtask

   task automatic test_integrate();
      int first = -1;
      set_ch(0, 10);
      bus.sel = '0;
      for (int c = 0; c < 24; c++) begin
         step();
         if (first < 0 && msp[0]) first = c;
         n_tests++; if (bus.spike !== exp_spike()) begin n_fail++; $display("FAIL integ_spike c=%0d got=%b exp=%b", c, bus.spike, exp_spike()); end
         n_tests++; if (bus.refrac !== exp_refrac()) begin n_fail++; $display("FAIL integ_refrac c=%0d got=%b exp=%b", c, bus.refrac, exp_refrac()); end
         n_tests++; if (bus.v_out !== exp_vout()) begin n_fail++; $display("FAIL integ_vout c=%0d got=%0d exp=%0d", c, bus.v_out, exp_vout()); end
         n_tests++; if (bus.cnt_out !== exp_cnt()) begin n_fail++; $display("FAIL integ_cnt c=%0d got=%0d exp=%0d", c, bus.cnt_out, exp_cnt()); end
      end
      // From v=0 with +10: 10, 26, 78, then clamps at 255 and fires on the fourth step.
      n_tests++; if (first != 3) begin n_fail++; $display("FAIL integ_first_spike got=%0d exp=3", first); end
      set_ch(0, 0);
   endtask

   task automatic test_clamp();
      bus.i_in = '0;
      bus.sel = SEL_W'(1);
      set_ch(1, 5); step();
      n_tests++; if (bus.v_out !== 8'd5) begin n_fail++; $display("FAIL clamp_up5 got=%0d exp=5", bus.v_out); end
      set_ch(1, -128); step();
      n_tests++; if (bus.v_out !== 8'd0) begin n_fail++; $display("FAIL clamp_low got=%0d exp=0", bus.v_out); end
      bus.v_thresh = 8'd255;
      set_ch(1, 127); step();
      n_tests++; if (bus.v_out !== 8'd127) begin n_fail++; $display("FAIL clamp_127 got=%0d exp=127", bus.v_out); end
      step();
      n_tests++; if (bus.spike[1] !== 1'b1) begin n_fail++; $display("FAIL clamp_high_spike got=%b exp=1", bus.spike[1]); end
      n_tests++; if (bus.v_out !== bus.v_reset) begin n_fail++; $display("FAIL clamp_high_vreset got=%0d exp=%0d", bus.v_out, bus.v_reset); end
      n_tests++; if (bus.refrac !== exp_refrac()) begin n_fail++; $display("FAIL clamp_refrac got=%b exp=%b", bus.refrac, exp_refrac()); end
      bus.i_in = '0;
      repeat (REFRAC) step();
   endtask

   task automatic test_ena_freeze();
      int guard = 0;
      bus.v_thresh = '0; bus.v_reset = 8'd33; bus.sel = SEL_W'(2);
      while (mrc[2] != REFRAC && guard < 10) begin step(); guard++; end
      n_tests++; if (mrc[2] != REFRAC) begin n_fail++; $display("FAIL freeze_no_spike got=%0d exp=%0d", mrc[2], REFRAC); end
      step();
      bus.ena = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         n_tests++; if (bus.refrac !== exp_refrac()) begin n_fail++; $display("FAIL freeze_refrac c=%0d got=%b exp=%b", c, bus.refrac, exp_refrac()); end
         n_tests++; if (bus.spike !== '0) begin n_fail++; $display("FAIL freeze_spike c=%0d got=%b exp=0", c, bus.spike); end
         n_tests++; if (bus.v_out !== exp_vout()) begin n_fail++; $display("FAIL freeze_vout c=%0d got=%0d exp=%0d", c, bus.v_out, exp_vout()); end
      end
      bus.ena = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         n_tests++; if (bus.refrac !== exp_refrac()) begin n_fail++; $display("FAIL resume_refrac c=%0d got=%b exp=%b", c, bus.refrac, exp_refrac()); end
         n_tests++; if (bus.spike !== exp_spike()) begin n_fail++; $display("FAIL resume_spike c=%0d got=%b exp=%b", c, bus.spike, exp_spike()); end
      end
   endtask

   task automatic test_saturate();
      int guard = 0;
      bus.v_thresh = '0; bus.sel = SEL_W'(3);
      repeat (1250) step();
      n_tests++; if (bus.cnt_out !== 8'd255) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=255", bus.cnt_out); end
      n_tests++; if (bus.cnt_out !== exp_cnt()) begin n_fail++; $display("FAIL sat_cnt_model got=%0d exp=%0d", bus.cnt_out, exp_cnt()); end
      while (mrc[3] != 0 && guard < 10) begin step(); guard++; end
      bus.cnt_clr = 1'b1;
      step();
      bus.cnt_clr = 1'b0;
      n_tests++; if (bus.spike[3] !== 1'b1) begin n_fail++; $display("FAIL clr_spike got=%b exp=1", bus.spike[3]); end
      n_tests++; if (bus.cnt_out !== 8'd0) begin n_fail++; $display("FAIL clr_cnt got=%0d exp=0", bus.cnt_out); end
   endtask

   task automatic test_async_reset();
      int guard = 0;
      bus.v_thresh = '0; bus.v_reset = 8'd40; bus.sel = SEL_W'(1);
      while (mrc[1] == 0 && guard < 10) begin step(); guard++; end
      n_tests++; if (bus.refrac[1] !== 1'b1) begin n_fail++; $display("FAIL arst_pre_refrac got=%b exp=1", bus.refrac[1]); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++; if (bus.spike !== '0) begin n_fail++; $display("FAIL arst_spike got=%b exp=0", bus.spike); end
      n_tests++; if (bus.refrac !== '0) begin n_fail++; $display("FAIL arst_refrac got=%b exp=0", bus.refrac); end
      n_tests++; if (bus.v_out !== '0) begin n_fail++; $display("FAIL arst_vout got=%0d exp=0", bus.v_out); end
      n_tests++; if (bus.cnt_out !== '0) begin n_fail++; $display("FAIL arst_cnt got=%0d exp=0", bus.cnt_out); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus.i_in = $urandom;
         if (c % 16 == 0) begin
            bus.v_thresh = WIDTH'($urandom_range(255, 60));
            bus.v_reset  = WIDTH'($urandom_range(100, 0));
            bus.v_rest   = WIDTH'($urandom_range(64, 0));
         end
         bus.ena     = ($urandom_range(9, 0) != 0);
         bus.cnt_clr = ($urandom_range(49, 0) == 0);
         bus.sel     = SEL_W'($urandom_range(N_CH - 1, 0));
         step();
         n_tests++; if (bus.spike !== exp_spike()) begin n_fail++; $display("FAIL rnd_spike c=%0d got=%b exp=%b", c, bus.spike, exp_spike()); end
         n_tests++; if (bus.refrac !== exp_refrac()) begin n_fail++; $display("FAIL rnd_refrac c=%0d got=%b exp=%b", c, bus.refrac, exp_refrac()); end
         n_tests++; if (bus.v_out !== exp_vout()) begin n_fail++; $display("FAIL rnd_vout c=%0d got=%0d exp=%0d", c, bus.v_out, exp_vout()); end
         n_tests++; if (bus.cnt_out !== exp_cnt()) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bus.cnt_out, exp_cnt()); end
      end
      bus.ena = 1'b1; bus.cnt_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_quiet();
      test_integrate();
      test_clamp();
      test_ena_freeze();
      test_saturate();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
